// File: rtl/axi_fill_pkg.sv
// Shared definitions for the AXI4-Lite fill master: FSM states and AXI constants.
package axi_fill_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    RESP   = 2'd2,
    FINISH = 2'd3
  } fill_state_e;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam int         WORD_BYTES = 4;
  localparam int         COUNT_W    = 16;

endpackage

// File: rtl/axi_fill_master.sv
// AXI4-Lite write master that fills a block of 32-bit words with one constant value,
// one transaction at a time, aborting on the first non-OKAY write response.
module axi_fill_master
  import axi_fill_pkg::*;
#(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 19
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,
  input  logic                            start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   base_addr,
  input  logic [COUNT_W-1:0]              word_count,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   fill_data,
  output logic                            busy,
  output logic                            done,
  output logic                            error,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;

  fill_state_e       r_state, w_next;
  logic [AW-1:0]     r_addr;
  logic [DW-1:0]     r_data;
  logic [COUNT_W-1:0] r_remain;
  logic              r_awvalid, r_wvalid, r_aw_done, r_w_done, r_bready;
  logic              r_busy, r_done, r_error, r_err_pend;

  logic              w_accept, w_aw_hs, w_w_hs, w_both, w_bhs, w_bok, w_last;
  logic [AW-1:0]     w_base, w_addr_nxt;

  // busy stays high through the done cycle, so it also blocks a start landing there
  assign w_accept   = (r_state == IDLE) && start && !r_busy;
  assign w_aw_hs    = r_awvalid & M_AXI_AWREADY;
  assign w_w_hs     = r_wvalid & M_AXI_WREADY;
  assign w_both     = (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);
  assign w_bhs      = r_bready & M_AXI_BVALID;
  assign w_bok      = (M_AXI_BRESP == RESP_OKAY);
  assign w_last     = (r_remain == COUNT_W'(1));
  assign w_base     = base_addr & ~AW'(WORD_BYTES - 1);
  assign w_addr_nxt = r_addr + AW'(WORD_BYTES);

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) r_state <= IDLE;
    else                r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = (word_count == '0) ? FINISH : WRITE;
      WRITE:   if (w_both)   w_next = RESP;
      RESP:    if (w_bhs)    w_next = (!w_bok || w_last) ? FINISH : WRITE;
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      r_addr     <= '0;
      r_data     <= '0;
      r_remain   <= '0;
      r_awvalid  <= 1'b0;
      r_wvalid   <= 1'b0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_bready   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_err_pend <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (r_done) r_busy <= 1'b0;
          if (w_accept) begin
            r_addr     <= w_base;
            r_data     <= fill_data;
            r_remain   <= word_count;
            r_error    <= 1'b0;
            r_err_pend <= 1'b0;
            r_busy     <= 1'b1;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            if (word_count != '0) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_both) r_bready <= 1'b1;
        end
        RESP: begin
          if (w_bhs) begin
            r_bready <= 1'b0;
            if (!w_bok) begin
              r_err_pend <= 1'b1;
            end else begin
              r_remain <= r_remain - COUNT_W'(1);
              if (!w_last) begin
                r_addr    <= w_addr_nxt;
                r_awvalid <= 1'b1;
                r_wvalid  <= 1'b1;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
              end
            end
          end
        end
        FINISH: begin
          // error is published together with done, not when the bad response arrives
          r_done  <= 1'b1;
          r_error <= r_err_pend;
        end
        default: ;
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign error         = r_error;
  assign M_AXI_AWADDR  = r_addr;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_data;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = r_bready;

endmodule

// File: tb/tb_axi_fill_master.sv
// Scoreboarded bench for axi_fill_master with a stallable AXI4-Lite write slave model.
module tb_axi_fill_master;

  logic        gclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [18:0] base_addr = '0;
  logic [15:0] word_count = '0;
  logic [31:0] fill_data = '0;
  logic        busy, done, error;
  logic [18:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  always #5 gclk = ~gclk;

  axi_fill_master #(.C_M_AXI_DATA_WIDTH(32), .C_M_AXI_ADDR_WIDTH(19)) dut (
    .M_AXI_ACLK(gclk), .M_AXI_ARESETN(rst_n),
    .start(start), .base_addr(base_addr), .word_count(word_count), .fill_data(fill_data),
    .busy(busy), .done(done), .error(error),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready)
  );

  int n_chk = 0, n_err = 0;
  int done_cnt = 0, n_aw = 0, aw_cyc = 0, wv_cyc = 0;
  int aw_viol = 0, w_viol = 0, ost_viol = 0;
  int txn = 0, err_idx = -1, cfg_aw = 0, cfg_w = 0, aw_ctr = 0, w_ctr = 0;
  logic aw_got = 0, w_got = 0, b_pend = 0, w_prev = 0;
  logic [31:0] w_hold = '0;
  logic [18:0] exp_addr[$];
  logic [31:0] exp_data[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
  end

  // Slave model: readies are decided on the falling edge, so any VALID&READY seen here
  // is the handshake the next rising edge will commit.
  always @(negedge gclk) begin
    if (!rst_n) begin
      awready = 0; wready = 0; bvalid = 0;
      aw_got = 0; w_got = 0; b_pend = 0; w_prev = 0;
      exp_addr.delete(); exp_data.delete();
    end else begin
      if (done) done_cnt++;
      if (awvalid) aw_cyc++;
      if (wvalid) wv_cyc++;
      if (awvalid && aw_got) aw_viol++;
      if (wvalid && w_got) w_viol++;
      if ((awvalid || wvalid) && b_pend) ost_viol++;
      if (wvalid && !w_got && w_prev && wdata !== w_hold) w_viol++;
      w_prev = wvalid && !w_got;
      w_hold = wdata;
      bvalid = b_pend;
      bresp  = (txn == err_idx) ? 2'b10 : 2'b00;
      if (bvalid && bready) begin
        b_pend = 0; aw_got = 0; w_got = 0; txn++;
        aw_ctr = cfg_aw; w_ctr = cfg_w;
      end
      awready = 0;
      if (awvalid && !aw_got) begin
        if (aw_ctr == 0) awready = 1; else aw_ctr--;
      end
      wready = 0;
      if (wvalid && !w_got) begin
        if (w_ctr == 0) wready = 1; else w_ctr--;
      end
      if (awvalid && awready) begin
        aw_got = 1; n_aw++;
        chk("awprot", 32'(awprot), 32'h0);
        if (exp_addr.size() == 0) chk("aw_extra", 32'(awaddr), 32'hFFFF_FFFF);
        else chk("awaddr", 32'(awaddr), 32'(exp_addr.pop_front()));
      end
      if (wvalid && wready) begin
        w_got = 1;
        chk("wstrb", 32'(wstrb), 32'hF);
        if (exp_data.size() == 0) chk("w_extra", wdata, ~wdata);
        else chk("wdata", wdata, exp_data.pop_front());
      end
      if (aw_got && w_got) b_pend = 1;
    end
  end

  task automatic run_fill(input string tag, input logic [18:0] base, input logic [15:0] cnt,
                          input logic [31:0] data, input int aw_w, input int w_w, input int err_i,
                          input int exp_n, input logic exp_err);
    int d0, a0, v0, cyc;
    logic [18:0] a;
    a = base & 19'h7FFFC;
    for (int i = 0; i < exp_n; i++) begin
      exp_addr.push_back(a); exp_data.push_back(data);
      a = a + 19'd4;
    end
    cfg_aw = aw_w; cfg_w = w_w; aw_ctr = aw_w; w_ctr = w_w; err_idx = err_i; txn = 0;
    d0 = done_cnt; a0 = n_aw; v0 = aw_cyc + wv_cyc;
    aw_viol = 0; w_viol = 0; ost_viol = 0;
    @(negedge gclk);
    start = 1; base_addr = base; word_count = cnt; fill_data = data;
    @(negedge gclk);
    start = 0; base_addr = ~base; word_count = 16'hFFFF; fill_data = ~data;
    chk({tag, ":busy_on"}, 32'(busy), 1);
    chk({tag, ":err_clr"}, 32'(error), 0);
    cyc = 1;
    while (!done && cyc < 400) begin
      // a stray start mid-operation must be ignored
      if (cyc == 3) start = 1; else start = 0;
      @(negedge gclk);
      cyc++;
    end
    start = 0;
    chk({tag, ":done"}, 32'(done), 1);
    chk({tag, ":busy_done"}, 32'(busy), 1);
    chk({tag, ":error"}, 32'(error), 32'(exp_err));
    if (cnt == 0) begin
      chk({tag, ":latency"}, 32'(cyc), 2);
      chk({tag, ":no_valid"}, 32'(aw_cyc + wv_cyc - v0), 0);
    end
    @(negedge gclk);
    chk({tag, ":busy_off"}, 32'(busy), 0);
    chk({tag, ":done_off"}, 32'(done), 0);
    chk({tag, ":err_hold"}, 32'(error), 32'(exp_err));
    chk({tag, ":pulses"}, 32'(done_cnt - d0), 1);
    chk({tag, ":writes"}, 32'(n_aw - a0), 32'(exp_n));
    chk({tag, ":sb_empty"}, 32'(exp_addr.size() + exp_data.size()), 0);
    chk({tag, ":valid_drop"}, 32'(aw_viol + w_viol), 0);
    chk({tag, ":outstanding"}, 32'(ost_viol), 0);
  endtask

  initial begin
    int d0, cyc;
    repeat (3) @(negedge gclk);
    chk("rst:busy", 32'(busy), 0);
    chk("rst:done", 32'(done), 0);
    chk("rst:error", 32'(error), 0);
    chk("rst:valid", 32'({awvalid, wvalid, bready}), 0);
    chk("rst:awaddr", 32'(awaddr), 0);
    chk("rst:wdata", wdata, 0);
    rst_n = 1;
    @(negedge gclk);

    run_fill("basic",  19'h00100, 16'd3, 32'hDEADBEEF, 0, 0, -1, 3, 1'b0);
    run_fill("zero",   19'h00100, 16'd0, 32'h11111111, 0, 0, -1, 0, 1'b0);
    run_fill("wstall", 19'h00040, 16'd1, 32'h12345678, 0, 5, -1, 1, 1'b0);
    run_fill("awstall",19'h00080, 16'd2, 32'hA5A5A5A5, 4, 0, -1, 2, 1'b0);
    run_fill("bad",    19'h00200, 16'd4, 32'hCAFEF00D, 0, 0, 1, 2, 1'b1);
    repeat (3) @(negedge gclk);
    chk("bad:err_sticky", 32'(error), 1);
    run_fill("wrap",   19'h7FFFC, 16'd2, 32'h0BADC0DE, 1, 2, -1, 2, 1'b0);
    run_fill("unalign",19'h00203, 16'd2, 32'h5A5A0001, 0, 0, -1, 2, 1'b0);

    // reset while the second word's AWVALID is up
    exp_addr.push_back(19'h00300); exp_data.push_back(32'h77777777);
    cfg_aw = 3; cfg_w = 0; aw_ctr = 3; w_ctr = 0; err_idx = -1; txn = 0;
    @(negedge gclk);
    start = 1; base_addr = 19'h00300; word_count = 16'd3; fill_data = 32'h77777777;
    @(negedge gclk);
    start = 0;
    cyc = 0;
    while (!(txn == 1 && awvalid) && cyc < 200) begin
      @(negedge gclk);
      cyc++;
    end
    chk("rst_mid:reached", 32'(txn == 1 && awvalid), 1);
    d0 = done_cnt;
    rst_n = 0;
    #1;
    chk("rst_mid:valid", 32'({awvalid, wvalid, bready}), 0);
    chk("rst_mid:status", 32'({busy, done, error}), 0);
    chk("rst_mid:awaddr", 32'(awaddr), 0);
    chk("rst_mid:wdata", wdata, 0);
    repeat (4) @(negedge gclk);
    chk("rst_mid:no_done", 32'(done_cnt - d0), 0);
    rst_n = 1;
    @(negedge gclk);
    run_fill("after_rst", 19'h00400, 16'd1, 32'h01020304, 0, 0, -1, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
